// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch queue: the fetch packet layout,
// the A64 NOP encoding shown to decode when the queue is empty, and the PC step.
package cpu_pkg;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  localparam logic [31:0] NOP_INSTR = 32'hD503201F;
  localparam logic [63:0] PC_INCR   = 64'd4;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle.
// master: fetch stage + decoder side. slave: the queue.
interface fetch_queue_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);

  logic               fetch_valid;
  logic [ADDR_W-1:0]  fetch_pc;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_ready;
  logic               dec_valid;
  logic [ADDR_W-1:0]  dec_pc;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc4;
  logic               dec_ready;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc4
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_instr, dec_pc4
  );

endinterface

// File: rtl/adder64.sv
// 64-bit adder shared across the datapath; wraps modulo 2^64.
module adder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/fetch_queue_ptr.sv
// Pointer/occupancy bookkeeping for fetch_queue: write pointer, read pointer,
// entry count and the derived full/empty flags. Flush overrides push and pop.
module fetch_queue_ptr #(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next-state: flush wins; otherwise pointers advance (wrapping) on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode. Buffers up to DEPTH {pc, instr}
// packets, flushes on a taken branch, and supplies pc+4 for BL link values.
// No same-cycle bypass: a packet pushed in cycle N is visible in cycle N+1.
// Optional build macro FETCH_QUEUE_STATS_EN adds saturating stall_cycles and
// flush_count counters.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH   = 2,
  parameter  int ADDR_W  = 64,
  parameter  int INSTR_W = 32,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  fetch_queue_if.slave   fq,
  output logic [CW-1:0]  count
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    flush_count
`endif
);

  logic          push, pop, full, empty;
  logic [PW-1:0] wr_ptr, rd_ptr;
  fetch_pkt_t    mem_q [DEPTH];
  fetch_pkt_t    head;

  // Ready depends only on occupancy and reset, never on dec_ready.
  assign fq.fetch_ready = ~full & reset;
  assign push           = fq.fetch_valid & fq.fetch_ready;
  assign pop            = ~empty & fq.dec_ready;

  fetch_queue_ptr #(.DEPTH(DEPTH)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .push_i   (push),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count),
    .full_o   (full),
    .empty_o  (empty)
  );

  // Packet storage; a push coinciding with a flush is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr] <= '{pc: fq.fetch_pc, instr: fq.fetch_instr};
    end
  end

  // Head presentation: an empty queue shows PC 0 and a NOP.
  always_comb begin
    head         = mem_q[rd_ptr];
    fq.dec_valid = ~empty;
    fq.dec_pc    = '0;
    fq.dec_instr = NOP_INSTR;
    if (!empty) begin
      fq.dec_pc    = head.pc;
      fq.dec_instr = head.instr;
    end
  end

  adder64 u_pc4 (
    .a   (fq.dec_pc),
    .b   (PC_INCR),
    .sum (fq.dec_pc4)
  );

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q, flush_count_q;

  // Saturating event counters: fetch stalled by a full queue, and flushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (fq.fetch_valid && !fq.fetch_ready && stall_cycles_q != '1)
        stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush && flush_count_q != '1)
        flush_count_q <= flush_count_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } mpkt_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  count;
`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  fetch_queue_if #(.ADDR_W(64), .INSTR_W(32)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(64), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .flush (flush),
    .fq    (fq.slave),
    .count (count)
`ifdef FETCH_QUEUE_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  mpkt_t       mq[$];
  int unsigned m_stall, m_flush;
  int unsigned nchecks, nerrors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach its end, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [63:0] epc;
    logic [31:0] ein;
    epc = (mq.size() != 0) ? mq[0].pc : 64'd0;
    ein = (mq.size() != 0) ? mq[0].instr : NOP_INSTR;
    check_val({tag, ".fetch_ready"}, 64'(fq.fetch_ready), 64'(rst_n && mq.size() < DEPTH));
    check_val({tag, ".dec_valid"},   64'(fq.dec_valid),   64'(mq.size() != 0));
    check_val({tag, ".dec_pc"},      fq.dec_pc,           epc);
    check_val({tag, ".dec_pc4"},     fq.dec_pc4,          epc + 64'd4);
    check_val({tag, ".dec_instr"},   64'(fq.dec_instr),   64'(ein));
    check_val({tag, ".count"},       64'(count),          64'(mq.size()));
`ifdef FETCH_QUEUE_STATS_EN
    check_val({tag, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
    check_val({tag, ".flush_count"},  64'(flush_count),  64'(m_flush));
`endif
  endtask

  // One cycle: drive inputs after the falling edge, check, clock, update model.
  task automatic step(input string tag, input bit fl, input bit fv,
                      input logic [63:0] pc, input logic [31:0] ins, input bit dr);
    bit do_push, do_pop;
    flush          = fl;
    fq.fetch_valid = fv;
    fq.fetch_pc    = pc;
    fq.fetch_instr = ins;
    fq.dec_ready   = dr;
    #1;
    check_outputs(tag);
    do_push = fv && (mq.size() < DEPTH);
    do_pop  = dr && (mq.size() != 0);
    @(posedge clk);
    if (fv && !do_push) m_stall++;
    if (fl) begin
      m_flush++;
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back('{pc: pc, instr: ins});
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] s0, f0;
    nchecks = 0; nerrors = 0; m_stall = 0; m_flush = 0;
    rst_n = 1'b0; flush = 1'b0;
    fq.fetch_valid = 1'b0; fq.fetch_pc = '0; fq.fetch_instr = '0; fq.dec_ready = 1'b0;
    #1;
    check_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Streaming with decode always ready: one cycle of latency, count stays 1.
    step("stream0", 0, 1, 64'h0, 32'hAAAA0000, 1);
    step("stream1", 0, 1, 64'h4, 32'hAAAA0004, 1);
    step("stream2", 0, 1, 64'h8, 32'hAAAA0008, 1);
    check_val("stream.count1", 64'(count), 64'd1);
    step("stream3", 0, 0, 64'h0, 32'h0, 1);

    // Decode stall: fill, refuse third push, then pop and accept it.
    step("stall0", 0, 1, 64'h10, 32'hBBBB0010, 0);
    step("stall1", 0, 1, 64'h14, 32'hBBBB0014, 0);
    check_val("stall.full_ready", 64'(fq.fetch_ready), 64'd0);
    step("stall2", 0, 1, 64'h18, 32'hBBBB0018, 0);
    step("stall3", 0, 1, 64'h18, 32'hBBBB0018, 1);
    step("stall4", 0, 1, 64'h18, 32'hBBBB0018, 0);
    check_val("stall.pc14_head", fq.dec_pc, 64'h14);
    step("drain0", 0, 0, 64'h0, 32'h0, 1);
    step("drain1", 0, 0, 64'h0, 32'h0, 1);

    // Flush with simultaneous push and pop drops everything.
    step("flush0", 0, 1, 64'h20, 32'hCCCC0020, 0);
    step("flush1", 0, 1, 64'h24, 32'hCCCC0024, 0);
    step("flush2", 1, 1, 64'h40, 32'hCCCC0040, 1);
    check_val("flush.instr_nop", 64'(fq.dec_instr), 64'(NOP_INSTR));
    step("flush3", 0, 0, 64'h0, 32'h0, 0);

    // Alternating push/pop across pointer wrap.
    step("wrap0", 0, 1, 64'h100, 32'hDDDD0100, 0);
    for (int i = 1; i < 5; i++)
      step("wrap", 0, 1, 64'h100 + 64'(4 * i), 32'hDDDD0100 + 32'(4 * i), 1);
    step("wrap5", 0, 0, 64'h0, 32'h0, 1);
    step("wrap6", 0, 0, 64'h0, 32'h0, 1);

`ifdef FETCH_QUEUE_STATS_EN
    s0 = stall_cycles; f0 = flush_count;
    step("stats0", 0, 1, 64'h200, 32'h1, 0);
    step("stats1", 0, 1, 64'h204, 32'h2, 0);
    for (int i = 0; i < 3; i++) step("stats_hold", 0, 1, 64'h208, 32'h3, 0);
    step("stats_flush", 1, 0, 64'h0, 32'h0, 0);
    step("stats_end", 0, 0, 64'h0, 32'h0, 0);
    check_val("stats.stall_delta", 64'(stall_cycles - s0), 64'd3);
    check_val("stats.flush_delta", 64'(flush_count - f0), 64'd1);
`else
    s0 = '0; f0 = '0;
`endif

    // Reset mid-run with two entries queued.
    step("rst_fill0", 0, 1, 64'h300, 32'hEEEE0300, 0);
    step("rst_fill1", 0, 1, 64'h304, 32'hEEEE0304, 0);
    rst_n = 1'b0;
    #1;
    mq.delete(); m_stall = 0; m_flush = 0;
    check_outputs("reset_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst0", 0, 1, 64'h400, 32'hFFFF0400, 0);
    check_val("post_rst.accepted", 64'(count), 64'd1);

    // Randomized traffic including flushes and wrapping PCs.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] rpc;
      rpc = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFFC;
      step("rand", ($urandom_range(0, 15) == 0), 1'($urandom), rpc, $urandom,
           ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
